// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: pipeline request/response and backing-memory signals of the data cache
interface dcache_ctrl_if;
  logic [15:0] Addr, DataIn, DataOut, mem_addr, mem_wdata, mem_rdata;
  logic Rd, Wr, Done, CacheHit, Stall, Err, mem_rd, mem_wr, mem_ack;
  modport master (
    output Addr, DataIn, Rd, Wr, mem_rdata, mem_ack,
    input  DataOut, Done, CacheHit, Stall, Err, mem_addr, mem_wdata, mem_rd, mem_wr
  );
  modport slave (
    input  Addr, DataIn, Rd, Wr, mem_rdata, mem_ack,
    output DataOut, Done, CacheHit, Stall, Err, mem_addr, mem_wdata, mem_rd, mem_wr
  );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache, one 16-bit word per line
module dcache_ctrl #(
  parameter int INDEX_BITS = 8
) (
  input logic clk,
  input logic rst,
  dcache_ctrl_if.slave bus
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_BITS = 15 - INDEX_BITS;
  typedef enum logic [1:0] {IDLE, EVICT, FILL, FINISH} state_t;
  state_t state, nextState;
  logic [LINES-1:0] validArr, dirtyArr;
  logic [TAG_BITS-1:0] tagArr [LINES];
  logic [15:0] dataArr [LINES];
  logic [15:0] fillData, fillWord;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag;
  logic req, illegal, hit, accept, okHit, miss, victimDirty;
  assign idx = bus.Addr[INDEX_BITS:1];
  assign tag = bus.Addr[15:INDEX_BITS+1];
  // request decode; IDLE outputs are suppressed while rst is high so reset wins
  always_comb begin
    req = bus.Rd | bus.Wr;
    illegal = (bus.Rd & bus.Wr) | (req & bus.Addr[0]);
    hit = validArr[idx] && (tagArr[idx] == tag);
    accept = (state == IDLE) && !rst && req;
    okHit = accept && !illegal && hit;
    miss = accept && !illegal && !hit;
    victimDirty = validArr[idx] & dirtyArr[idx];
    fillWord = bus.Wr ? bus.DataIn : bus.mem_rdata;
  end
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : nextState;
  // next-state logic; mem_ack outside EVICT/FILL is ignored
  always_comb begin
    nextState = state == IDLE  ? (miss ? (victimDirty ? EVICT : FILL) : IDLE) :
                state == EVICT ? (bus.mem_ack ? FILL : EVICT) :
                state == FILL  ? (bus.mem_ack ? FINISH : FILL) : IDLE;
  end
  // outputs; memory requests come straight from state so they start the cycle after the miss
  always_comb begin
    bus.Err = accept && illegal;
    bus.CacheHit = okHit;
    bus.Done = (accept && illegal) || okHit || (state == FINISH);
    bus.Stall = miss || (state == EVICT) || (state == FILL);
    bus.DataOut = (okHit && bus.Rd) ? dataArr[idx] : (state == FINISH) ? fillData : '0;
    bus.mem_wr = state == EVICT;
    bus.mem_rd = state == FILL;
    bus.mem_addr = (state == EVICT) ? {tagArr[idx], idx, 1'b0} : (state == FILL) ? bus.Addr : '0;
    bus.mem_wdata = (state == EVICT) ? dataArr[idx] : '0;
  end
  // line arrays: store hits mark dirty, fills allocate; only valid/dirty are cleared by reset
  always_ff @(posedge clk)
    if (rst) begin
      validArr <= '0;
      dirtyArr <= '0;
    end else if (okHit && bus.Wr) begin
      dataArr[idx] <= bus.DataIn;
      dirtyArr[idx] <= 1'b1;
    end else if (state == FILL && bus.mem_ack) begin
      dataArr[idx] <= fillWord;
      tagArr[idx] <= tag;
      validArr[idx] <= 1'b1;
      dirtyArr[idx] <= bus.Wr;
    end
  // filled word held for the FINISH cycle
  always_ff @(posedge clk)
    if (rst) fillData <= '0;
    else if (state == FILL && bus.mem_ack) fillData <= fillWord;
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed self-checking bench for dcache_ctrl
module tb_dcache_ctrl;
  logic clk, rst;
  int total, passes, fails;
  dcache_ctrl_if bus();
  dcache_ctrl #(.INDEX_BITS(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  // free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  // directed sequence: inputs change 1 time unit after the edge, outputs checked 2 units later
  initial begin
    logic [15:0] sAddr [8];
    logic [15:0] sData [8];
    total = 0; passes = 0; fails = 0;
    rst = 1'b1;
    bus.Rd = 0; bus.Wr = 0; bus.Addr = 0; bus.DataIn = 0; bus.mem_rdata = 0; bus.mem_ack = 0;
    cyc(); cyc(); #2;
    chk("reset_done", bus.Done, 0);
    chk("reset_stall", bus.Stall, 0);
    chk("reset_memrd", bus.mem_rd, 0);
    chk("reset_memwr", bus.mem_wr, 0);
    chk("reset_dataout", bus.DataOut, 0);
    cyc(); rst = 0; #2;
    chk("idle_done", bus.Done, 0);
    chk("idle_memaddr", bus.mem_addr, 0);
    // cold load 0x0040, L=4
    cyc(); bus.Rd = 1; bus.Addr = 16'h0040; #2;
    chk("cold_stall", bus.Stall, 1);
    chk("cold_done", bus.Done, 0);
    chk("cold_memrd_reg", bus.mem_rd, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(); bus.mem_ack = (i == 3); bus.mem_rdata = (i == 3) ? 16'hBEEF : 16'h0000; #2;
      chk("cold_memrd", bus.mem_rd, 1);
      chk("cold_memaddr", bus.mem_addr, 16'h0040);
      chk("cold_fill_stall", bus.Stall, 1);
    end
    cyc(); bus.mem_ack = 0; #2;
    chk("cold_fin_done", bus.Done, 1);
    chk("cold_fin_hit", bus.CacheHit, 0);
    chk("cold_fin_data", bus.DataOut, 16'hBEEF);
    chk("cold_fin_stall", bus.Stall, 0);
    chk("cold_fin_memrd", bus.mem_rd, 0);
    cyc(); #2;
    chk("reload_done", bus.Done, 1);
    chk("reload_hit", bus.CacheHit, 1);
    chk("reload_data", bus.DataOut, 16'hBEEF);
    // store hit then conflicting load forces write-back
    cyc(); bus.Rd = 0; bus.Wr = 1; bus.DataIn = 16'h1234; #2;
    chk("sthit_done", bus.Done, 1);
    chk("sthit_hit", bus.CacheHit, 1);
    chk("sthit_stall", bus.Stall, 0);
    cyc(); bus.Wr = 0; bus.Rd = 1; bus.Addr = 16'h0240; #2;
    chk("conf_stall", bus.Stall, 1);
    chk("conf_done", bus.Done, 0);
    cyc(); #2;
    chk("evict_memwr", bus.mem_wr, 1);
    chk("evict_memrd", bus.mem_rd, 0);
    chk("evict_addr", bus.mem_addr, 16'h0040);
    chk("evict_wdata", bus.mem_wdata, 16'h1234);
    cyc(); bus.mem_ack = 1; #2;
    chk("evict_hold_memwr", bus.mem_wr, 1);
    chk("evict_hold_addr", bus.mem_addr, 16'h0040);
    cyc(); bus.mem_rdata = 16'h5678; #2;
    chk("conf_fill_memrd", bus.mem_rd, 1);
    chk("conf_fill_memwr", bus.mem_wr, 0);
    chk("conf_fill_addr", bus.mem_addr, 16'h0240);
    cyc(); bus.mem_ack = 0; #2;
    chk("conf_fin_done", bus.Done, 1);
    chk("conf_fin_hit", bus.CacheHit, 0);
    chk("conf_fin_data", bus.DataOut, 16'h5678);
    cyc(); #2;
    chk("conf_rehit", bus.CacheHit, 1);
    chk("conf_rehit_data", bus.DataOut, 16'h5678);
    // store miss allocate at 0x0100; memory data must not replace the store data
    cyc(); bus.Rd = 0; bus.Wr = 1; bus.Addr = 16'h0100; bus.DataIn = 16'hAAAA; #2;
    chk("stmiss_stall", bus.Stall, 1);
    chk("stmiss_memwr0", bus.mem_wr, 0);
    cyc(); bus.mem_ack = 1; bus.mem_rdata = 16'h0F0F; #2;
    chk("stmiss_memrd", bus.mem_rd, 1);
    chk("stmiss_memwr1", bus.mem_wr, 0);
    chk("stmiss_addr", bus.mem_addr, 16'h0100);
    cyc(); bus.mem_ack = 0; #2;
    chk("stmiss_fin_done", bus.Done, 1);
    chk("stmiss_fin_memwr", bus.mem_wr, 0);
    cyc(); bus.Wr = 0; bus.Rd = 1; #2;
    chk("stmiss_load_hit", bus.CacheHit, 1);
    chk("stmiss_load_data", bus.DataOut, 16'hAAAA);
    // illegal requests
    cyc(); bus.Wr = 1; bus.Addr = 16'h0600; bus.DataIn = 16'h9999; #2;
    chk("ill_rdwr_err", bus.Err, 1);
    chk("ill_rdwr_done", bus.Done, 1);
    chk("ill_rdwr_stall", bus.Stall, 0);
    cyc(); bus.Wr = 0; bus.Addr = 16'h0241; #2;
    chk("ill_odd_err", bus.Err, 1);
    chk("ill_odd_done", bus.Done, 1);
    chk("ill_odd_stall", bus.Stall, 0);
    cyc(); bus.Rd = 0; #2;
    chk("ill_no_memrd", bus.mem_rd, 0);
    chk("ill_no_memwr", bus.mem_wr, 0);
    chk("ill_idle_err", bus.Err, 0);
    // load after illegal store misses; reset on 2nd FILL cycle
    cyc(); bus.Rd = 1; bus.Addr = 16'h0600; #2;
    chk("post_ill_miss", bus.Stall, 1);
    chk("post_ill_done", bus.Done, 0);
    cyc(); #2;
    chk("rstfill_memrd1", bus.mem_rd, 1);
    cyc(); rst = 1; #2;
    chk("rstfill_memrd2", bus.mem_rd, 1);
    cyc(); rst = 0; bus.Rd = 0; bus.mem_ack = 1; bus.mem_rdata = 16'h7777; #2;
    chk("rstfill_memrd_drop", bus.mem_rd, 0);
    chk("rstfill_done", bus.Done, 0);
    chk("rstfill_stall", bus.Stall, 0);
    chk("rstfill_memaddr", bus.mem_addr, 0);
    chk("rstfill_dataout", bus.DataOut, 0);
    cyc(); bus.mem_ack = 0; #2;
    chk("late_ack_memrd", bus.mem_rd, 0);
    chk("late_ack_done", bus.Done, 0);
    cyc(); bus.Rd = 1; #2;
    chk("after_rst_miss", bus.Stall, 1);
    chk("after_rst_hit", bus.CacheHit, 0);
    cyc(); bus.mem_ack = 1; bus.mem_rdata = 16'h6060; #2;
    chk("refill_memrd", bus.mem_rd, 1);
    cyc(); bus.mem_ack = 0; #2;
    chk("refill_done", bus.Done, 1);
    chk("refill_data", bus.DataOut, 16'h6060);
    // reset cleared every line, so earlier residents must miss now
    cyc(); bus.Addr = 16'h0100; #2;
    chk("rst_cleared_0100", bus.Stall, 1);
    cyc(); bus.Rd = 0; bus.mem_ack = 1; bus.mem_rdata = 16'hAAAA; #2;
    chk("refill2_memrd", bus.mem_rd, 1);
    cyc(); bus.mem_ack = 0; #2;
    chk("refill2_done", bus.Done, 1);
    cyc(); bus.Rd = 1; bus.Addr = 16'h0240; #2;
    chk("rst_cleared_0240", bus.Stall, 1);
    cyc(); bus.Rd = 1; bus.mem_ack = 1; bus.mem_rdata = 16'h5678; #2;
    chk("refill3_memrd", bus.mem_rd, 1);
    cyc(); bus.mem_ack = 0; #2;
    chk("refill3_data", bus.DataOut, 16'h5678);
    // hit streaming across three resident lines
    sAddr[0] = 16'h0240; sData[0] = 16'h5678;
    sAddr[1] = 16'h0100; sData[1] = 16'hAAAA;
    sAddr[2] = 16'h0600; sData[2] = 16'h6060;
    for (int i = 3; i < 8; i++) begin
      sAddr[i] = sAddr[i-3];
      sData[i] = sData[i-3];
    end
    for (int i = 0; i < 8; i++) begin
      cyc(); bus.Rd = 1; bus.Addr = sAddr[i]; #2;
      chk("stream_done", bus.Done, 1);
      chk("stream_hit", bus.CacheHit, 1);
      chk("stream_stall", bus.Stall, 0);
      chk("stream_data", bus.DataOut, sData[i]);
    end
    // simultaneous reset and store hit: reset wins
    cyc(); rst = 1; bus.Rd = 0; bus.Wr = 1; bus.Addr = 16'h0600; bus.DataIn = 16'h1111; #2;
    chk("rst_req_done", bus.Done, 0);
    chk("rst_req_hit", bus.CacheHit, 0);
    chk("rst_req_stall", bus.Stall, 0);
    cyc(); rst = 0; bus.Wr = 0; bus.Rd = 0; #2;
    chk("rst_req_idle", bus.Done, 0);
    cyc(); #2;
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
